// File: rtl/reaction_timer_ctrl.sv
// Round sequencer for the reaction-time game: arms a random delay from the LFSR,
// lights GO, measures the response in ms ticks and tracks the best time.
module reaction_timer_ctrl #(
   parameter int TICKS_PER_MS = 50000,
   parameter int MIN_DELAY_MS = 1000,
   parameter int MAX_RT_MS    = 9999
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        react,
   input  logic [11:0] lfsr_val,
   output logic        lfsr_step,
   output logic        led_go,
   output logic        busy,
   output logic [13:0] rt_ms,
   output logic [13:0] best_ms,
   output logic        too_soon,
   output logic        timeout
);

   localparam int              PW          = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [PW-1:0]   PRESC_LAST  = PW'(TICKS_PER_MS - 1);
   localparam logic [11:0]     DELAY_FLOOR = 12'(MIN_DELAY_MS);
   localparam logic [13:0]     RT_LAST     = 14'(MAX_RT_MS - 1);
   localparam logic [13:0]     BEST_NONE   = 14'h3FFF;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT,
      GO,
      DONE,
      FOUL
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [PW-1:0]  presc;
   logic [11:0]    delay_cnt;
   logic [13:0]    rt_cnt;
   logic           tick;
   logic           wait_last;
   logic           go_last;

   // ms tick only exists while the prescaler is running (WAIT and GO)
   always_comb begin
      tick      = 1'b0;
      wait_last = 1'b0;
      go_last   = 1'b0;
      if ((state == WAIT) || (state == GO)) begin
         tick = (presc == PRESC_LAST);
      end
      wait_last = tick && (state == WAIT) && (delay_cnt == 12'd1);
      go_last   = tick && (state == GO) && (rt_cnt == RT_LAST);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, FOUL: begin
            if (start) begin
               state_nxt = ARM;
            end
         end
         ARM: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            if (react) begin
               state_nxt = FOUL;
            end else if (wait_last) begin
               state_nxt = GO;
            end
         end
         GO: begin
            if (react) begin
               state_nxt = DONE;
            end else if (go_last) begin
               state_nxt = FOUL;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_step <= 1'b0;
         led_go    <= 1'b0;
         busy      <= 1'b0;
         rt_ms     <= '0;
         best_ms   <= BEST_NONE;
         too_soon  <= 1'b0;
         timeout   <= 1'b0;
         presc     <= '0;
         delay_cnt <= '0;
         rt_cnt    <= '0;
      end else begin
         lfsr_step <= (state_nxt == ARM);
         led_go    <= (state_nxt == GO);
         busy      <= (state_nxt == ARM) || (state_nxt == WAIT) || (state_nxt == GO);
         case (state)
            IDLE, DONE, FOUL: begin
               if (start) begin
                  too_soon <= 1'b0;
                  timeout  <= 1'b0;
               end
            end
            ARM: begin
               // lfsr_val already holds the post-step value here
               delay_cnt <= DELAY_FLOOR + {1'b0, lfsr_val[10:0]};
               presc     <= '0;
            end
            WAIT: begin
               presc <= tick ? '0 : presc + 1'b1;
               if (tick) begin
                  delay_cnt <= delay_cnt - 12'd1;
               end
               if (react) begin
                  too_soon <= 1'b1;
               end else if (wait_last) begin
                  rt_cnt <= '0;
               end
            end
            GO: begin
               presc <= tick ? '0 : presc + 1'b1;
               if (react) begin
                  rt_ms <= rt_cnt;
                  if (rt_cnt < best_ms) begin
                     best_ms <= rt_cnt;
                  end
               end else if (tick) begin
                  rt_cnt <= rt_cnt + 14'd1;
                  if (go_last) begin
                     timeout <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with a fast ms tick and a behavioural 12-bit LFSR.
module tb_reaction_timer_ctrl;

   localparam int TPM = 4;

   logic        clk      = 1'b0;
   logic        reset_n  = 1'b0;
   logic        start    = 1'b0;
   logic        react    = 1'b0;
   logic [11:0] lfsr_q;
   logic        seed_ld  = 1'b0;
   logic [11:0] seed_val = 12'h000;
   int          n_steps  = 0;

   logic        lfsr_step;
   logic        led_go;
   logic        busy;
   logic [13:0] rt_ms;
   logic [13:0] best_ms;
   logic        too_soon;
   logic        timeout;

   int n_checks = 0;
   int n_fail   = 0;

   reaction_timer_ctrl #(
      .TICKS_PER_MS (TPM),
      .MIN_DELAY_MS (1000),
      .MAX_RT_MS    (9999)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .react     (react),
      .lfsr_val  (lfsr_q),
      .lfsr_step (lfsr_step),
      .led_go    (led_go),
      .busy      (busy),
      .rt_ms     (rt_ms),
      .best_ms   (best_ms),
      .too_soon  (too_soon),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] lfsr_next(input logic [11:0] q);
      return {q[10:0], q[11] ^ q[10] ^ q[9] ^ q[3]};
   endfunction

   // Behavioural LFSR: advances on the rising edge of lfsr_step, loadable for directed delays
   always @(posedge lfsr_step or posedge seed_ld) begin
      if (seed_ld) begin
         lfsr_q <= seed_val;
      end else begin
         lfsr_q  <= lfsr_next(lfsr_q);
         n_steps <= n_steps + 1;
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: observed no end of test, expected end before 1500000 ns");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_lfsr_step"}, lfsr_step, 0);
      chk({pfx, "_led_go"},    led_go,    0);
      chk({pfx, "_busy"},      busy,      0);
      chk({pfx, "_rt_ms"},     rt_ms,     0);
      chk({pfx, "_best_ms"},   best_ms,   14'h3FFF);
      chk({pfx, "_too_soon"},  too_soon,  0);
      chk({pfx, "_timeout"},   timeout,   0);
   endtask

   // Seed the LFSR, start a round (optionally with a simultaneous react) and land in WAIT
   task automatic arm(input logic [11:0] sd, input logic with_react, input string pfx);
      seed_val = sd;
      seed_ld  = 1'b1;
      #1;
      seed_ld  = 1'b0;
      start    = 1'b1;
      react    = with_react;
      step(1);
      start    = 1'b0;
      react    = 1'b0;
      chk({pfx, "_arm_step"}, lfsr_step, 1);
      chk({pfx, "_arm_busy"}, busy,      1);
      step(1);
      chk({pfx, "_wait_step"},    lfsr_step, 0);
      chk({pfx, "_wait_toosoon"}, too_soon,  0);
      chk({pfx, "_wait_timeout"}, timeout,   0);
   endtask

   // From the first WAIT cycle, confirm GO rises exactly d*TPM cycles later
   task automatic wait_go(input int d, input string pfx);
      step(d * TPM - 1);
      chk({pfx, "_go_early"}, led_go, 0);
      step(1);
      chk({pfx, "_go_on"},    led_go, 1);
   endtask

   task automatic pulse_react();
      react = 1'b1;
      step(1);
      react = 1'b0;
   endtask

   initial begin
      // Reset and idle behaviour
      step(2);
      chk_reset("rst");
      pulse_react();
      chk_reset("rst_react");
      reset_n = 1'b1;
      step(2);
      pulse_react();
      step(2);
      chk_reset("idle_react");
      chk("idle_no_step", n_steps, 0);

      // Delay from lfsr 12'h805 -> 1005 ms
      arm(12'h402, 1'b0, "dly");
      chk("dly_nsteps", n_steps, 1);
      wait_go(1005, "dly");
      step(7 * TPM);
      pulse_react();
      chk("dly_rt",    rt_ms,   7);
      chk("dly_led",   led_go,  0);
      chk("dly_busy",  busy,    0);
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      step(1);
      chk("dly_rst_best", best_ms, 14'h3FFF);

      // Best tracking over three rounds (delay 1000 ms each)
      arm(12'hC00, 1'b0, "b250");
      wait_go(1000, "b250");
      step(250 * TPM);
      pulse_react();
      chk("b250_rt",   rt_ms,   250);
      chk("b250_best", best_ms, 250);
      chk("b250_led",  led_go,  0);

      arm(12'hC00, 1'b1, "b180");
      chk("b180_rt_kept", rt_ms, 250);
      wait_go(1000, "b180");
      step(180 * TPM);
      pulse_react();
      chk("b180_rt",   rt_ms,   180);
      chk("b180_best", best_ms, 180);

      arm(12'hC00, 1'b0, "b300");
      wait_go(1000, "b300");
      step(300 * TPM);
      pulse_react();
      chk("b300_rt",   rt_ms,   300);
      chk("b300_best", best_ms, 180);

      // Early react 100 ms into WAIT
      arm(12'hC00, 1'b0, "foul");
      step(100 * TPM);
      pulse_react();
      chk("foul_toosoon", too_soon, 1);
      chk("foul_led",     led_go,   0);
      chk("foul_busy",    busy,     0);
      chk("foul_rt",      rt_ms,    300);
      chk("foul_best",    best_ms,  180);
      step(20);
      chk("foul_led_later", led_go,   0);
      chk("foul_hold",      too_soon, 1);

      // React coinciding with the final WAIT tick
      arm(12'hC00, 1'b0, "ftk");
      step(1000 * TPM - 1);
      chk("ftk_led_pre", led_go, 0);
      pulse_react();
      chk("ftk_toosoon", too_soon, 1);
      chk("ftk_led",     led_go,   0);
      chk("ftk_busy",    busy,     0);
      step(3);
      chk("ftk_led_later", led_go, 0);

      // Starts while busy are ignored; react on a tick captures the pre-increment count
      seed_val = 12'hC00;
      seed_ld  = 1'b1;
      #1;
      seed_ld  = 1'b0;
      start    = 1'b1;
      step(1);
      chk("edg_arm_step", lfsr_step, 1);
      step(1);
      start    = 1'b0;
      chk("edg_wait_step", lfsr_step, 0);
      chk("edg_wait_busy", busy,      1);
      step(100);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(1000 * TPM - 101 - 1);
      chk("edg_go_early", led_go, 0);
      step(1);
      chk("edg_go_on", led_go, 1);
      step(10);
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("edg_go_busy", busy,   1);
      chk("edg_go_led",  led_go, 1);
      step(203 - 11);
      pulse_react();
      chk("edg_rt",     rt_ms,   50);
      chk("edg_best",   best_ms, 50);
      chk("edg_led",    led_go,  0);
      chk("edg_nsteps", n_steps, 7);

      // Timeout after 9999 ms in GO
      arm(12'hC00, 1'b0, "tmo");
      wait_go(1000, "tmo");
      step(39995);
      chk("tmo_led_pre",     led_go,  1);
      chk("tmo_timeout_pre", timeout, 0);
      step(1);
      chk("tmo_led",      led_go,   0);
      chk("tmo_timeout",  timeout,  1);
      chk("tmo_toosoon",  too_soon, 0);
      chk("tmo_busy",     busy,     0);
      chk("tmo_rt",       rt_ms,    50);
      chk("tmo_best",     best_ms,  50);

      // Asynchronous reset in the middle of GO
      arm(12'hC00, 1'b0, "rgo");
      wait_go(1000, "rgo");
      step(30);
      reset_n = 1'b0;
      #1;
      chk_reset("rgo_now");
      step(2);
      reset_n = 1'b1;
      step(2);
      chk_reset("rgo_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
